// File: rtl/sysctrl_pkg.sv
// rtl/sysctrl_pkg.sv - command codes, status constants and helpers for sysctrl_gen
package sysctrl_pkg;

    localparam logic [7:0] CMD_STATUS  = 8'h00;
    localparam logic [7:0] CMD_LEDS    = 8'h01;
    localparam logic [7:0] CMD_COLOR   = 8'h02;
    localparam logic [7:0] CMD_BUTTONS = 8'h03;
    localparam logic [7:0] CMD_CFG_WR  = 8'h04;
    localparam logic [7:0] CMD_INT     = 8'h05;
    localparam logic [7:0] CMD_MASK    = 8'h06;
    localparam logic [7:0] CMD_CFG_RD  = 8'h07;

    localparam logic [7:0] STATUS_MAGIC0 = 8'h5c;
    localparam logic [7:0] STATUS_MAGIC1 = 8'h42;

    // Byte counter sticks here so long commands never wrap back to "idle" (0)
    localparam logic [3:0] CNT_MAX = 4'd15;

    function automatic logic [7:0] bit_rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/sysctrl_irq.sv
// rtl/sysctrl_irq.sv - interrupt mask, coldboot flag, ack pulses and int_out_n
module sysctrl_irq #(
    parameter int NUM_INT = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_INT-1:0] int_in,
    input  logic               ack_wr,
    input  logic               mask_wr,
    input  logic [NUM_INT-1:0] wr_data,
    output logic [NUM_INT-1:0] int_ack,
    output logic               int_out_n,
    output logic [7:0]         status
);

    logic [NUM_INT-1:0] int_mask;
    logic               coldboot;
    logic [NUM_INT-1:0] pending;

    // Ack pulses last one cycle; coldboot drops once channel 0 has been acked
    always_ff @(posedge clk) begin
        if (reset) begin
            int_ack  <= '0;
            int_mask <= '1;
            coldboot <= 1'b1;
        end else begin
            int_ack <= ack_wr ? wr_data : '0;
            if (mask_wr) begin
                int_mask <= wr_data;
            end
            if (int_ack[0]) begin
                coldboot <= 1'b0;
            end
        end
    end

    // Interrupt line and status byte {pending[7:1], coldboot}, zero-extended
    always_comb begin
        pending   = int_in & int_mask;
        int_out_n = ~((|pending) | coldboot);
        status    = 8'h00;
        status[0] = coldboot;
        for (int i = 1; i < NUM_INT; i++) begin
            status[i] = pending[i];
        end
    end

endmodule

// File: rtl/sysctrl_gen.sv
// rtl/sysctrl_gen.sv - MCU byte-command system controller; SYSCTRL_CFG_READBACK_EN enables CMD 7
module sysctrl_gen
    import sysctrl_pkg::*;
#(
    parameter logic [7:0]           CORE_ID      = 8'h02,
    parameter int                   NUM_CFG      = 32,
    parameter logic [7:0]           CFG_BASE     = 8'h40,
    parameter logic [NUM_CFG*8-1:0] CFG_DEFAULTS = '0,
    parameter int                   NUM_INT      = 8,
    parameter int                   NUM_LEDS     = 2,
    parameter int                   NUM_BUTTONS  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   data_in_strobe,
    input  logic                   data_in_start,
    input  logic [7:0]             data_in,
    output logic [7:0]             data_out,
    output logic                   int_out_n,
    input  logic [NUM_INT-1:0]     int_in,
    output logic [NUM_INT-1:0]     int_ack,
    input  logic [NUM_BUTTONS-1:0] buttons,
    output logic [NUM_LEDS-1:0]    leds,
    output logic [23:0]            color,
    output logic [NUM_CFG*8-1:0]   cfg,
    output logic                   cfg_wr,
    output logic [5:0]             cfg_idx
);

    localparam logic [7:0] NUM_CFG_B = 8'(NUM_CFG);
    localparam logic [5:0] LAST_IDX  = 6'(NUM_CFG - 1);

    logic [7:0] command;
    logic [3:0] count;
    logic [5:0] cfg_ptr;
    logic       cfg_ptr_ok;
    logic       byte_ok;
    logic       first_byte;
    logic [8:0] cfg_off;
    logic       id_ok;
    logic [7:0] btn_byte;
    logic [7:0] irq_status;
    logic       ack_wr;
    logic       mask_wr;

    // Byte qualification, config id decode and button zero-extension
    always_comb begin
        byte_ok    = data_in_strobe & ~data_in_start & (count != 4'd0);
        first_byte = byte_ok & (count == 4'd1);
        ack_wr     = first_byte & (command == CMD_INT);
        mask_wr    = first_byte & (command == CMD_MASK);
        cfg_off    = {1'b0, data_in} - {1'b0, CFG_BASE};
        id_ok      = ~cfg_off[8] & (cfg_off[7:0] < NUM_CFG_B);
        btn_byte   = 8'h00;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            btn_byte[i] = buttons[i];
        end
    end

`ifdef SYSCTRL_CFG_READBACK_EN
    logic [7:0] rd_byte;

    // Config readback mux; out-of-range pointer reads as zero
    always_comb begin
        rd_byte = 8'h00;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (cfg_ptr_ok && cfg_ptr == 6'(i)) begin
                rd_byte = cfg[i*8 +: 8];
            end
        end
    end
`endif

    // Command decode and execution, one step per strobed byte
    always_ff @(posedge clk) begin
        if (reset) begin
            command    <= CMD_STATUS;
            count      <= 4'd0;
            leds       <= '0;
            color      <= 24'h0;
            data_out   <= 8'h00;
            cfg        <= CFG_DEFAULTS;
            cfg_wr     <= 1'b0;
            cfg_idx    <= 6'd0;
            cfg_ptr    <= 6'd0;
            cfg_ptr_ok <= 1'b0;
        end else begin
            cfg_wr <= 1'b0;
            if (data_in_strobe && data_in_start) begin
                command <= data_in;
                count   <= 4'd1;
            end else if (byte_ok) begin
                if (count != CNT_MAX) begin
                    count <= count + 4'd1;
                end
                case (command)
                    CMD_STATUS: begin
                        case (count)
                            4'd1:    data_out <= STATUS_MAGIC0;
                            4'd2:    data_out <= STATUS_MAGIC1;
                            4'd3:    data_out <= CORE_ID;
                            4'd4:    data_out <= NUM_CFG_B;
                            default: ;
                        endcase
                    end
                    CMD_LEDS: begin
                        if (count == 4'd1) begin
                            leds <= data_in[NUM_LEDS-1:0];
                        end
                    end
                    CMD_COLOR: begin
                        case (count)
                            4'd1:    color[15:8]  <= bit_rev8(data_in);
                            4'd2:    color[7:0]   <= bit_rev8(data_in);
                            4'd3:    color[23:16] <= bit_rev8(data_in);
                            default: ;
                        endcase
                    end
                    CMD_BUTTONS: data_out <= btn_byte;
                    CMD_CFG_WR: begin
                        if (count == 4'd1) begin
                            cfg_ptr    <= cfg_off[5:0];
                            cfg_ptr_ok <= id_ok;
                        end else if (cfg_ptr_ok) begin
                            for (int i = 0; i < NUM_CFG; i++) begin
                                if (cfg_ptr == 6'(i)) begin
                                    cfg[i*8 +: 8] <= data_in;
                                end
                            end
                            cfg_wr     <= 1'b1;
                            cfg_idx    <= cfg_ptr;
                            cfg_ptr    <= cfg_ptr + 6'd1;
                            cfg_ptr_ok <= (cfg_ptr != LAST_IDX);
                        end
                    end
                    CMD_INT: data_out <= irq_status;
`ifdef SYSCTRL_CFG_READBACK_EN
                    CMD_CFG_RD: begin
                        if (count == 4'd1) begin
                            cfg_ptr    <= cfg_off[5:0];
                            cfg_ptr_ok <= id_ok;
                        end else begin
                            data_out <= rd_byte;
                            if (cfg_ptr_ok) begin
                                cfg_ptr    <= cfg_ptr + 6'd1;
                                cfg_ptr_ok <= (cfg_ptr != LAST_IDX);
                            end
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    sysctrl_irq #(
        .NUM_INT(NUM_INT)
    ) u_irq (
        .clk       (clk),
        .reset     (reset),
        .int_in    (int_in),
        .ack_wr    (ack_wr),
        .mask_wr   (mask_wr),
        .wr_data   (data_in[NUM_INT-1:0]),
        .int_ack   (int_ack),
        .int_out_n (int_out_n),
        .status    (irq_status)
    );

endmodule

// File: tb/tb_sysctrl_gen.sv
// tb/tb_sysctrl_gen.sv - directed self-checking bench for sysctrl_gen
module tb_sysctrl_gen;

    localparam logic [255:0] DEF = {232'h0, 8'h5A, 16'h0};

    logic         clk = 1'b0;
    logic         reset;
    logic         data_in_strobe;
    logic         data_in_start;
    logic [7:0]   data_in;
    logic [7:0]   data_out;
    logic         int_out_n;
    logic [7:0]   int_in;
    logic [7:0]   int_ack;
    logic [1:0]   buttons;
    logic [1:0]   leds;
    logic [23:0]  color;
    logic [255:0] cfg;
    logic         cfg_wr;
    logic [5:0]   cfg_idx;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_pulses = 0;
    int p0;
    logic [255:0] exp_cfg;
    logic [7:0]   rb0, rb1, rb2, rb3;

    always #5 clk = ~clk;

    sysctrl_gen #(
        .CFG_DEFAULTS(DEF)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .data_in_strobe (data_in_strobe),
        .data_in_start  (data_in_start),
        .data_in        (data_in),
        .data_out       (data_out),
        .int_out_n      (int_out_n),
        .int_in         (int_in),
        .int_ack        (int_ack),
        .buttons        (buttons),
        .leds           (leds),
        .color          (color),
        .cfg            (cfg),
        .cfg_wr         (cfg_wr),
        .cfg_idx        (cfg_idx)
    );

    always @(posedge clk) begin
        if (cfg_wr === 1'b1) wr_pulses++;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic st, input logic [7:0] b);
        @(negedge clk);
        data_in_strobe = 1'b1;
        data_in_start  = st;
        data_in        = b;
        @(negedge clk);
        data_in_strobe = 1'b0;
        data_in_start  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        data_in_strobe = 1'b0;
        data_in_start  = 1'b0;
        data_in = 8'h00;
        int_in  = 8'h00;
        buttons = 2'b00;
        do_reset();

        chk("rst_data_out", data_out, 8'h00);
        chk("rst_leds", leds, 2'b00);
        chk("rst_color", color, 24'h0);
        chk("rst_int_ack", int_ack, 8'h00);
        chk("rst_cfg", cfg, DEF);
        chk("rst_cfg_wr", cfg_wr, 1'b0);
        chk("rst_cfg_idx", cfg_idx, 6'd0);
        chk("rst_int_out_n", int_out_n, 1'b0);

        // bytes before any command byte are ignored
        send(1'b0, 8'h03);
        chk("idle_leds", leds, 2'b00);
        chk("idle_data_out", data_out, 8'h00);

        // status
        send(1'b1, 8'h00);
        send(1'b0, 8'h00); chk("status_b1", data_out, 8'h5c);
        send(1'b0, 8'h00); chk("status_b2", data_out, 8'h42);
        send(1'b0, 8'h00); chk("status_b3", data_out, 8'h02);
        send(1'b0, 8'h00); chk("status_b4", data_out, 8'h20);
        send(1'b0, 8'h00); chk("status_b5_hold", data_out, 8'h20);

        // leds
        send(1'b1, 8'h01);
        send(1'b0, 8'hFF); chk("leds_set", leds, 2'b11);
        send(1'b0, 8'h00); chk("leds_byte2_ignored", leds, 2'b11);

        // color with bit reversal
        send(1'b1, 8'h02);
        send(1'b0, 8'h01); chk("color_b1", color, 24'h008000);
        send(1'b0, 8'h03); chk("color_b2", color, 24'h0080C0);
        send(1'b0, 8'h0F); chk("color_b3", color, 24'hF080C0);

        // new start mid color command
        send(1'b1, 8'h02);
        send(1'b0, 8'h02); chk("color_restart_b1", color, 24'hF040C0);
        send(1'b1, 8'h01);
        send(1'b0, 8'h01);
        chk("restart_leds", leds, 2'b01);
        chk("restart_color_kept", color, 24'hF040C0);

        // buttons
        buttons = 2'b10;
        send(1'b1, 8'h03);
        send(1'b0, 8'h00); chk("buttons_a", data_out, 8'h02);
        buttons = 2'b01;
        send(1'b0, 8'h00); chk("buttons_b", data_out, 8'h01);

        // config write id 41
        exp_cfg = DEF;
        p0 = wr_pulses;
        send(1'b1, 8'h04);
        send(1'b0, 8'h41); chk("cfgw_id_no_pulse", cfg_wr, 1'b0);
        send(1'b0, 8'hAA);
        exp_cfg[15:8] = 8'hAA;
        chk("cfgw_wr1", cfg_wr, 1'b1);
        chk("cfgw_idx1", cfg_idx, 6'd1);
        chk("cfgw_cfg1", cfg, exp_cfg);
        send(1'b0, 8'hBB);
        exp_cfg[23:16] = 8'hBB;
        chk("cfgw_wr2", cfg_wr, 1'b1);
        chk("cfgw_idx2", cfg_idx, 6'd2);
        chk("cfgw_cfg2", cfg, exp_cfg);
        @(negedge clk);
        chk("cfgw_wr_low", cfg_wr, 1'b0);
        chk("cfgw_pulses", wr_pulses - p0, 2);

        // config write at last index, increment past end dropped
        p0 = wr_pulses;
        send(1'b1, 8'h04);
        send(1'b0, 8'h5F);
        send(1'b0, 8'h11);
        exp_cfg[255:248] = 8'h11;
        send(1'b0, 8'h22);
        chk("cfgw_end_wr_low", cfg_wr, 1'b0);
        chk("cfgw_end_idx", cfg_idx, 6'd31);
        chk("cfgw_end_cfg", cfg, exp_cfg);
        @(negedge clk);
        chk("cfgw_end_pulses", wr_pulses - p0, 1);

        // id below base is dropped
        p0 = wr_pulses;
        send(1'b1, 8'h04);
        send(1'b0, 8'h3F);
        send(1'b0, 8'h77);
        @(negedge clk);
        chk("cfgw_low_pulses", wr_pulses - p0, 0);
        chk("cfgw_low_cfg", cfg, exp_cfg);

        // config readback (or unknown command without the macro)
`ifdef SYSCTRL_CFG_READBACK_EN
        rb0 = 8'hAA; rb1 = 8'hBB; rb2 = 8'h11; rb3 = 8'h00;
`else
        rb0 = 8'h01; rb1 = 8'h01; rb2 = 8'h01; rb3 = 8'h01;
`endif
        send(1'b1, 8'h07);
        send(1'b0, 8'h41);
        send(1'b0, 8'h00); chk("cfgr_b0", data_out, rb0);
        send(1'b0, 8'h00); chk("cfgr_b1", data_out, rb1);
        send(1'b1, 8'h07);
        send(1'b0, 8'h5F);
        send(1'b0, 8'h00); chk("cfgr_last", data_out, rb2);
        send(1'b0, 8'h00); chk("cfgr_past_end", data_out, rb3);

        // interrupts: ack clears coldboot
        chk("irq_coldboot_low", int_out_n, 1'b0);
        send(1'b1, 8'h05);
        send(1'b0, 8'h01);
        chk("irq_ack_pulse", int_ack, 8'h01);
        chk("irq_status_cold", data_out, 8'h01);
        @(negedge clk);
        chk("irq_ack_end", int_ack, 8'h00);
        chk("irq_after_ack", int_out_n, 1'b1);
        send(1'b0, 8'h00);
        chk("irq_status_warm", data_out, 8'h00);

        // mask
        send(1'b1, 8'h06);
        send(1'b0, 8'hFB);
        int_in = 8'h04;
        #1 chk("irq_masked", int_out_n, 1'b1);
        int_in = 8'h08;
        #1 chk("irq_unmasked", int_out_n, 1'b0);
        send(1'b1, 8'h05);
        send(1'b0, 8'h00);
        chk("irq_status_pend", data_out, 8'h08);
        chk("irq_no_ack", int_ack, 8'h00);
        int_in = 8'h00;
        #1 chk("irq_idle", int_out_n, 1'b1);

        // counter saturation keeps the command alive
        buttons = 2'b11;
        send(1'b1, 8'h03);
        for (int i = 0; i < 17; i++) send(1'b0, 8'h00);
        chk("sat_a", data_out, 8'h03);
        buttons = 2'b10;
        send(1'b0, 8'h00);
        chk("sat_b", data_out, 8'h02);

        // reset mid-command aborts it
        send(1'b1, 8'h01);
        do_reset();
        send(1'b0, 8'h03);
        chk("abort_leds", leds, 2'b00);
        chk("abort_data_out", data_out, 8'h00);
        chk("abort_coldboot", int_out_n, 1'b0);
        chk("abort_cfg", cfg, DEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sysctrl_gen.md
SYSCTRL_GEN -- requirements
Module: sysctrl_gen

Interface
REQ-001 Parameter CORE_ID, default 8'h02, core id returned by status command.
REQ-002 Parameter NUM_CFG, default 32, number of 8-bit config registers (1..64).
REQ-003 Parameter CFG_BASE, default 8'h40, id byte mapped to config index 0.
REQ-004 Parameter CFG_DEFAULTS, default all-zero NUM_CFG*8 bits, reset values of the config table (index 0 in LSBs).
REQ-005 Parameter NUM_INT, default 8, interrupt channel count (1..8).
REQ-006 Parameter NUM_LEDS, default 2; parameter NUM_BUTTONS, default 2 (each 1..8).
REQ-007 clk  in  1  clock; reset is synchronous, active-high, named reset.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 data_in_strobe  in  1  one-cycle pulse per MCU byte; data_in_start  in  1  marks command byte; data_in  in  8  byte from MCU.
REQ-010 data_out  out  8  registered reply byte.
REQ-011 int_out_n  out  1  active-low interrupt to MCU; int_in  in  NUM_INT  request lines; int_ack  out  NUM_INT  one-cycle ack pulses.
REQ-012 buttons  in  NUM_BUTTONS; leds  out  NUM_LEDS; color  out  24.
REQ-013 cfg  out  NUM_CFG*8  flat config table; cfg_wr  out  1  one-cycle pulse per config write; cfg_idx  out  6  index of last write.

Function
REQ-014 Byte with strobe and start: command <= data_in, byte counter <= 1; start wins over any in-progress command.
REQ-015 Strobe without start with counter != 0: execute per command, counter increments, saturating at 15; counter 0 ignores bytes.
REQ-016 data_out updates on the clock edge that samples the strobe; holds otherwise.
REQ-017 CMD 0 status: bytes 1..4 return 8'h5c, 8'h42, CORE_ID, NUM_CFG.
REQ-018 CMD 1: byte 1 sets leds <= data_in[NUM_LEDS-1:0].
REQ-019 CMD 2: bytes 1,2,3 bit-reversed into color[15:8], color[7:0], color[23:16].
REQ-020 CMD 3: every byte returns buttons zero-extended.
REQ-021 CMD 4 config write: byte 1 = id; bytes 2.. write consecutive indices (id-CFG_BASE, auto-increment, no counter limit); cfg_wr pulses and cfg_idx updates the cycle after each write.
REQ-022 Index outside 0..NUM_CFG-1 (incl. id < CFG_BASE, or increment past end): write dropped, no cfg_wr pulse, no wrap.
REQ-023 CMD 5: byte 1 drives int_ack <= data_in for one cycle; every byte returns {pending[7:1], coldboot} zero-extended beyond NUM_INT.
REQ-024 CMD 6: byte 1 sets int_mask <= data_in[NUM_INT-1:0].
REQ-025 int_out_n = 0 when (int_in & int_mask) != 0 or coldboot = 1, else 1; combinational.
REQ-026 coldboot set by reset, cleared the cycle after int_ack[0] = 1.
REQ-027 Unknown commands: bytes ignored, data_out holds.

Reset
REQ-028 On reset: counter 0, command 0, leds 0, color 0, int_ack 0, int_mask all-ones, coldboot 1, cfg = CFG_DEFAULTS, cfg_wr 0, cfg_idx 0, data_out 0.
REQ-029 Reset mid-command aborts it; following non-start bytes ignored.

Configuration
REQ-030 Macro SYSCTRL_CFG_READBACK_EN defined: CMD 7 enabled; byte 1 = id, bytes 2.. return cfg at consecutive indices, 8'h00 when out of range.
REQ-031 Macro undefined: CMD 7 treated as unknown per REQ-027; no read mux synthesised.

Structure
REQ-032 Package sysctrl_pkg holds command codes (CMD_STATUS..CMD_CFG_RD), status magic 8'h5c/8'h42, counter saturation value.
REQ-033 Sub-module sysctrl_irq holds int_mask, coldboot, int_ack, int_out_n logic.

Verification
REQ-034 Start 8'h00 + 4 bytes -> data_out 5c, 42, 02, 20 (defaults).
REQ-035 CMD 4, id 8'h41, values AA BB -> cfg[15:8]=AA, cfg[23:16]=BB, two cfg_wr pulses, cfg_idx 1 then 2.
REQ-036 CMD 4, id 8'h5F, values 11 22 -> index 31 = 11, second write dropped, one cfg_wr pulse.
REQ-037 After reset int_out_n = 0; CMD 5 ack 8'h01 -> int_ack pulse, coldboot 0, int_out_n 1; int_in = 8'h04 with mask 8'hFB -> int_out_n stays 1.
REQ-038 New start byte mid CMD 2 after one byte -> color[15:8] kept, later bytes follow new command.
REQ-039 With SYSCTRL_CFG_READBACK_EN, CMD 7 id 8'h41 after REQ-035 -> data_out AA, BB; without macro -> data_out unchanged.
